math_adder_multiword_seq: RTL and testbench

Sequential multi-word adder/subtractor controller. Adds or subtracts WORDS·N-bit operands by running one shared N-bit ripple adder stage (math_adder_full_nbit, N bits wide) once per cycle, least-significant word first. A registered carry chains each word into the next. The block sits between a valid/ready request source and a valid/ready result sink, for wide arithmetic where a full-width adder is too large.

---
 rtl/math_adder_multiword_seq.sv | 153 +++++++++++++++
 tb/tb_math_adder_multiword_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/math_adder_multiword_seq.sv
// Sequential multi-word add/subtract: one shared N-bit ripple stage is reused
// once per word, LSW first, with a registered carry chaining the words.

module math_adder_full_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N:0] c;

    assign c[0] = i_c;

    for (genvar g = 0; g < N; g++) begin : g_bit
        assign o_sum[g] = i_a[g] ^ i_b[g] ^ c[g];
        assign c[g+1]   = (i_a[g] & i_b[g]) | (c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_carry = c[N];

endmodule

module math_adder_multiword_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [N*WORDS-1:0] i_a,
    input  logic [N*WORDS-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic [N*WORDS-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy
);

    localparam int W    = N * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            sub_q;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    sum_q, sum_d;
    logic [N-1:0]    a_word, b_word, add_sum;
    logic            add_carry;

    // Word select for the shared stage; B is inverted for subtract.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
                a_word = a_q[w*N +: N];
                b_word = b_q[w*N +: N];
            end
        end
    end

    math_adder_full_nbit #(.N(N)) u_add (
        .i_a    (a_word),
        .i_b    (b_word ^ {N{sub_q}}),
        .i_c    (carry_q),
        .o_sum  (add_sum),
        .o_carry(add_carry)
    );

    always_comb begin
        sum_d = sum_q;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
                sum_d[w*N +: N] = add_sum;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start_valid)     state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (i_done_ready)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_start_ready = (state_q == IDLE);
        o_done_valid  = (state_q == DONE);
        o_busy        = (state_q == RUN) || (state_q == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        sub_q   <= i_sub;
                        carry_q <= i_sub | i_c;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_carry;
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The carry register is frozen in DONE, so it doubles as the carry output.
    assign o_sum   = sum_q;
    assign o_carry = carry_q;

endmodule

// File: tb/tb_math_adder_multiword_seq.sv
// Randomized self-checking bench: 4-word and 1-word builds against an
// arithmetic reference model.

module tb_math_adder_multiword_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         sv, sr, dv, dr, c_i, sub_i, carry_o, busy;
    logic [W-1:0] a_i, b_i, sum_o;

    logic         sv1, sr1, dv1, dr1, c1, sub1, carry1, busy1;
    logic [N-1:0] a1, b1, sum1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    math_adder_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start_valid(sv), .o_start_ready(sr),
        .i_a(a_i), .i_b(b_i), .i_c(c_i), .i_sub(sub_i),
        .o_done_valid(dv), .i_done_ready(dr),
        .o_sum(sum_o), .o_carry(carry_o), .o_busy(busy)
    );

    math_adder_multiword_seq #(.N(N), .WORDS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start_valid(sv1), .o_start_ready(sr1),
        .i_a(a1), .i_b(b1), .i_c(c1), .i_sub(sub1),
        .o_done_valid(dv1), .i_done_ready(dr1),
        .o_sum(sum1), .o_carry(carry1), .o_busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {carry, sum} with the carry at bit w.
    function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic sub, input int w);
        logic [63:0] mask, full, s;
        logic        cy;
        mask = (64'd1 << w) - 64'd1;
        if (sub) begin
            s  = (a - b) & mask;
            cy = (a >= b);
        end else begin
            full = a + b + {63'd0, c};
            s    = full & mask;
            cy   = full[w];
        end
        return s | ({63'd0, cy} << w);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic sub, input int hold, input bit poke);
        logic [63:0] exp;
        int cyc;
        exp = ref_op({32'd0, a}, {32'd0, b}, c, sub, W);
        check_eq("idle_ready", {63'd0, sr}, 64'd1);
        sv = 1'b1; a_i = a; b_i = b; c_i = c; sub_i = sub;
        @(posedge clk); #1;
        sv = 1'b0;
        check_eq("busy_run", {63'd0, busy}, 64'd1);
        check_eq("ready_run", {63'd0, sr}, 64'd0);
        cyc = 0;
        while (!dv && cyc < 20) begin
            if (poke && cyc == 1) begin
                sv = 1'b1; a_i = ~a; b_i = ~b; sub_i = ~sub;
            end else begin
                sv = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        sv = 1'b0;
        check_eq("latency", 64'(cyc), 64'(WORDS));
        check_eq("sum", {32'd0, sum_o}, exp & 64'hFFFF_FFFF);
        check_eq("carry", {63'd0, carry_o}, 64'(exp[W]));
        for (int k = 0; k < hold; k++) begin
            sv = poke;
            @(posedge clk); #1;
            check_eq("hold_valid", {63'd0, dv}, 64'd1);
            check_eq("hold_sum", {32'd0, sum_o}, exp & 64'hFFFF_FFFF);
            check_eq("hold_carry", {63'd0, carry_o}, 64'(exp[W]));
            check_eq("hold_ready", {63'd0, sr}, 64'd0);
        end
        sv = 1'b0;
        dr = 1'b1;
        @(posedge clk); #1;
        dr = 1'b0;
        check_eq("valid_drop", {63'd0, dv}, 64'd0);
        check_eq("ready_back", {63'd0, sr}, 64'd1);
        check_eq("busy_drop", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op1(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic sub);
        logic [63:0] exp;
        exp = ref_op({56'd0, a}, {56'd0, b}, c, sub, N);
        sv1 = 1'b1; a1 = a; b1 = b; c1 = c; sub1 = sub;
        @(posedge clk); #1;
        sv1 = 1'b0;
        check_eq("w1_not_yet", {63'd0, dv1}, 64'd0);
        @(posedge clk); #1;
        check_eq("w1_valid", {63'd0, dv1}, 64'd1);
        check_eq("w1_sum", {56'd0, sum1}, exp & 64'hFF);
        check_eq("w1_carry", {63'd0, carry1}, 64'(exp[N]));
        dr1 = 1'b1;
        @(posedge clk); #1;
        dr1 = 1'b0;
        check_eq("w1_ready_back", {63'd0, sr1}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        sv = 1'b0; dr = 1'b0; a_i = '0; b_i = '0; c_i = 1'b0; sub_i = 1'b0;
        sv1 = 1'b0; dr1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0;
        #2;
        check_eq("rst_ready", {63'd0, sr}, 64'd1);
        check_eq("rst_valid", {63'd0, dv}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_sum", {32'd0, sum_o}, 64'd0);
        check_eq("rst_carry", {63'd0, carry_o}, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 0, 1'b0);
        run_op(32'd5,         32'd3,         1'b0, 1'b1, 0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 5, 1'b1);

        // Reset after two RUN edges; partial sum must vanish at once.
        sv = 1'b1; a_i = 32'h1234_5678; b_i = 32'h1111_1111; c_i = 1'b0; sub_i = 1'b0;
        @(posedge clk); #1;
        sv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sum", {32'd0, sum_o}, 64'd0);
        check_eq("mid_rst_carry", {63'd0, carry_o}, 64'd0);
        check_eq("mid_rst_valid", {63'd0, dv}, 64'd0);
        check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("mid_rst_ready", {63'd0, sr}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        run_op1(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op1(8'h00, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_op1(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
